// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions used by both the display encoder and the scan decoder.
// Segment vectors are active-low, bit order [6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b0000001;
    localparam logic [6:0] GLYPH_1     = 7'b1001111;
    localparam logic [6:0] GLYPH_2     = 7'b0010010;
    localparam logic [6:0] GLYPH_3     = 7'b0000110;
    localparam logic [6:0] GLYPH_4     = 7'b1001100;
    localparam logic [6:0] GLYPH_5     = 7'b0100100;
    localparam logic [6:0] GLYPH_6     = 7'b0100000;
    localparam logic [6:0] GLYPH_7     = 7'b0001111;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0000100;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b1100000;
    localparam logic [6:0] GLYPH_C     = 7'b0110001;
    localparam logic [6:0] GLYPH_D     = 7'b1000010;
    localparam logic [6:0] GLYPH_E     = 7'b0110000;
    localparam logic [6:0] GLYPH_F     = 7'b0111000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Stability FSM: waiting for a one-hot select, counting a stable run, run already captured.
    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_LOCKED = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: active-low segment pattern -> hex nibble plus legality flags.
// The blank pattern is reported with is_blank=1 and legal=0; anything off-table is illegal.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       legal,
    output logic       is_blank
);

    // Table lookup of the received pattern against the shared glyph set
    always_comb begin
        nibble   = 4'h0;
        legal    = 1'b1;
        is_blank = 1'b0;
        case (seg_n)
            GLYPH_0:     nibble = 4'h0;
            GLYPH_1:     nibble = 4'h1;
            GLYPH_2:     nibble = 4'h2;
            GLYPH_3:     nibble = 4'h3;
            GLYPH_4:     nibble = 4'h4;
            GLYPH_5:     nibble = 4'h5;
            GLYPH_6:     nibble = 4'h6;
            GLYPH_7:     nibble = 4'h7;
            GLYPH_8:     nibble = 4'h8;
            GLYPH_9:     nibble = 4'h9;
            GLYPH_A:     nibble = 4'hA;
            GLYPH_B:     nibble = 4'hB;
            GLYPH_C:     nibble = 4'hC;
            GLYPH_D:     nibble = 4'hD;
            GLYPH_E:     nibble = 4'hE;
            GLYPH_F:     nibble = 4'hF;
            GLYPH_BLANK: begin
                legal    = 1'b0;
                is_blank = 1'b1;
            end
            default:     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus. A (segments, digit select) pair must be
// held for STABLE_CYCLES consecutive cycles before it is captured, which rejects scan
// transitions and ghosting. Captured digits assemble into an NDIG-digit frame.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter  int NDIG          = 8,
    parameter  int STABLE_CYCLES = 4,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [6:0]        seg_n,
    input  logic [NDIG-1:0]   dig_en,
    output logic [4*NDIG-1:0] value,
    output logic [NDIG-1:0]   digit_ok,
    output logic [NDIG-1:0]   blank,
    output logic              frame_valid,
    output logic              glyph_err
);

    scan_state_t       state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [6:0]        prev_seg_r;
    logic [NDIG-1:0]   prev_dig_r;
    logic [4*NDIG-1:0] value_r;
    logic [NDIG-1:0]   ok_r;
    logic [NDIG-1:0]   blank_r;
    logic [NDIG-1:0]   seen_r;
    logic              frame_valid_r;
    logic              glyph_err_r;

    logic [NDIG-1:0]   dig_m1_s;
    logic              onehot_s;
    logic              same_s;
    logic              capture_s;
    logic [NDIG-1:0]   new_seen_s;
    logic [3:0]        nibble_s;
    logic              legal_s;
    logic              is_blank_s;

    seg7_glyph_decode u_decode (
        .seg_n    (seg_n),
        .nibble   (nibble_s),
        .legal    (legal_s),
        .is_blank (is_blank_s)
    );

    // One-hot test, run stability and the capture strobe for the current cycle
    always_comb begin
        dig_m1_s   = dig_en - NDIG'(1);
        onehot_s   = (dig_en != {NDIG{1'b0}}) && ((dig_en & dig_m1_s) == {NDIG{1'b0}});
        same_s     = (seg_n == prev_seg_r) && (dig_en == prev_dig_r);
        new_seen_s = seen_r | dig_en;
        if ((state_r == ST_COUNT) && onehot_s && same_s &&
            (cnt_r == CNT_W'(STABLE_CYCLES - 1))) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Input history and stability FSM; a capture locks until the pair changes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_WAIT;
            cnt_r      <= {CNT_W{1'b0}};
            prev_seg_r <= 7'h00;
            prev_dig_r <= {NDIG{1'b0}};
        end else begin
            prev_seg_r <= seg_n;
            prev_dig_r <= dig_en;
            if (clear) begin
                state_r <= ST_WAIT;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                case (state_r)
                    ST_WAIT: begin
                        if (onehot_s) begin
                            state_r <= ST_COUNT;
                            cnt_r   <= CNT_W'(1);
                        end else begin
                            cnt_r   <= {CNT_W{1'b0}};
                        end
                    end
                    ST_COUNT: begin
                        if (!onehot_s) begin
                            state_r <= ST_WAIT;
                            cnt_r   <= {CNT_W{1'b0}};
                        end else if (!same_s) begin
                            cnt_r   <= CNT_W'(1);
                        end else if (capture_s) begin
                            state_r <= ST_LOCKED;
                            cnt_r   <= CNT_W'(STABLE_CYCLES);
                        end else begin
                            cnt_r   <= cnt_r + CNT_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (!onehot_s) begin
                            state_r <= ST_WAIT;
                            cnt_r   <= {CNT_W{1'b0}};
                        end else if (!same_s) begin
                            state_r <= ST_COUNT;
                            cnt_r   <= CNT_W'(1);
                        end else begin
                            state_r <= ST_LOCKED;
                        end
                    end
                    default: begin
                        state_r <= ST_WAIT;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // Per-digit capture registers, seen mask and single-cycle frame/error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r       <= {(4*NDIG){1'b0}};
            ok_r          <= {NDIG{1'b0}};
            blank_r       <= {NDIG{1'b0}};
            seen_r        <= {NDIG{1'b0}};
            frame_valid_r <= 1'b0;
            glyph_err_r   <= 1'b0;
        end else if (clear) begin
            seen_r        <= {NDIG{1'b0}};
            frame_valid_r <= 1'b0;
            glyph_err_r   <= 1'b0;
        end else if (capture_s) begin
            for (int k = 0; k < NDIG; k++) begin
                if (dig_en[k]) begin
                    value_r[4*k +: 4] <= legal_s ? nibble_s : 4'h0;
                    ok_r[k]           <= legal_s;
                    blank_r[k]        <= is_blank_s;
                end
            end
            glyph_err_r <= !legal_s && !is_blank_s;
            if (new_seen_s == {NDIG{1'b1}}) begin
                frame_valid_r <= 1'b1;
                seen_r        <= {NDIG{1'b0}};
            end else begin
                frame_valid_r <= 1'b0;
                seen_r        <= new_seen_s;
            end
        end else begin
            frame_valid_r <= 1'b0;
            glyph_err_r   <= 1'b0;
        end
    end

    assign value       = value_r;
    assign digit_ok    = ok_r;
    assign blank       = blank_r;
    assign frame_valid = frame_valid_r;
    assign glyph_err   = glyph_err_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (NDIG=8, STABLE_CYCLES=4).
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [6:0]  seg_n;
    logic [7:0]  dig_en;
    logic [31:0] value;
    logic [7:0]  digit_ok;
    logic [7:0]  blank;
    logic        frame_valid;
    logic        glyph_err;

    int n_checks = 0;
    int n_fail   = 0;
    int fv_cnt, ge_cnt, fv_at, ge_at;
    int tot_fv, tot_ge, fv_digit;

    logic [6:0] gl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seg7_scan_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .seg_n       (seg_n),
        .dig_en      (dig_en),
        .value       (value),
        .digit_ok    (digit_ok),
        .blank       (blank),
        .frame_valid (frame_valid),
        .glyph_err   (glyph_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a pair for n cycles, sampling 1 time unit after each rising edge.
    task automatic hold(input logic [7:0] d, input logic [6:0] s, input int n);
        dig_en = d;
        seg_n  = s;
        fv_cnt = 0; ge_cnt = 0; fv_at = 0; ge_at = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (frame_valid === 1'b1) begin
                fv_cnt++;
                if (fv_at == 0) fv_at = i;
            end
            if (glyph_err === 1'b1) begin
                ge_cnt++;
                if (ge_at == 0) ge_at = i;
            end
        end
    endtask

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seg_n  = 7'($urandom);
            dig_en = 8'($urandom);
            clear  = 1'($urandom);
            @(posedge clk); #1;
        end
        check("rst_value", value, 32'h0);
        check("rst_ok", {24'h0, digit_ok}, 32'h0);
        check("rst_blank", {24'h0, blank}, 32'h0);
        check("rst_pulses", {30'h0, frame_valid, glyph_err}, 32'h0);
        rst = 1'b0;
        clear = 1'b0;
        hold(8'h00, 7'h7F, 2);
        check("post_rst_pulses", fv_cnt + ge_cnt, 32'd0);

        // Single digit: capture visible in the 5th cycle, never repeated
        hold(8'h04, gl[2], 3);
        check("d2_early_ok", {24'h0, digit_ok}, 32'h0);
        hold(8'h04, gl[2], 1);
        check("d2_value", value, 32'h0000_0200);
        check("d2_ok", {24'h0, digit_ok}, 32'h04);
        hold(8'h04, gl[2], 20);
        check("d2_hold_pulses", fv_cnt + ge_cnt, 32'd0);
        check("d2_hold_value", value, 32'h0000_0200);

        // Full scan 0..7: one frame pulse, on the capture of digit 7
        tot_fv = 0; tot_ge = 0; fv_digit = -1;
        for (int k = 0; k < 8; k++) begin
            hold(8'(1 << k), gl[k], 4);
            tot_fv += fv_cnt; tot_ge += ge_cnt;
            if (fv_cnt != 0) fv_digit = k * 8 + fv_at;
        end
        check("scan_fv_count", tot_fv, 32'd1);
        check("scan_fv_when", fv_digit, 32'd60);
        check("scan_ge", tot_ge, 32'd0);
        check("scan_value", value, 32'h7654_3210);
        check("scan_ok", {24'h0, digit_ok}, 32'hFF);

        // Illegal glyph on digit 0 after a legal 'A'
        hold(8'h01, gl[10], 4);
        check("d0_a_value", value, 32'h7654_321A);
        hold(8'h01, 7'b1010101, 20);
        check("illegal_ge_count", ge_cnt, 32'd1);
        check("illegal_ge_when", ge_at, 32'd4);
        check("illegal_value", value, 32'h7654_3210);
        check("illegal_ok", {24'h0, digit_ok}, 32'hFE);
        check("illegal_blank", {24'h0, blank}, 32'h0);
        hold(8'h01, 7'b1111111, 4);
        check("blank_flag", {24'h0, blank}, 32'h01);
        check("blank_ok", {24'h0, digit_ok}, 32'hFE);
        check("blank_ge", ge_cnt + fv_cnt, 32'd0);

        // Glitches: pattern flipping every 3 cycles, then multi-hot select
        tot_ge = 0;
        for (int r = 0; r < 4; r++) begin
            hold(8'h02, gl[5], 3); tot_ge += ge_cnt;
            hold(8'h02, gl[6], 3); tot_ge += ge_cnt;
        end
        check("flip_no_capture", value, 32'h7654_3210);
        check("flip_ge", tot_ge, 32'd0);
        hold(8'h06, gl[8], 10);
        check("multihot_no_capture", value, 32'h7654_3210);
        // Mid-run change restarts the count
        hold(8'h02, gl[5], 2);
        hold(8'h02, gl[9], 3);
        check("restart_early", value, 32'h7654_3210);
        hold(8'h02, gl[9], 1);
        check("restart_capture", value, 32'h7654_3290);

        // Clear on the capture edge of the last missing digit
        tot_fv = 0;
        for (int k = 2; k < 7; k++) begin
            hold(8'(1 << k), gl[k], 4);
            tot_fv += fv_cnt;
        end
        check("pre_clear_fv", tot_fv, 32'd0);
        hold(8'h80, gl[15], 3);
        clear = 1'b1;
        hold(8'h80, gl[15], 1);
        clear = 1'b0;
        check("clear_fv", fv_cnt, 32'd0);
        check("clear_no_capture", value, 32'h7654_3290);
        hold(8'h80, gl[15], 4);
        check("after_clear_capture", value, 32'hF654_3290);
        check("after_clear_fv", fv_cnt, 32'd0);
        // Seen mask was emptied: frame completes only at digit 6
        tot_fv = 0; fv_digit = -1;
        for (int k = 0; k < 7; k++) begin
            hold(8'(1 << k), gl[k], 4);
            tot_fv += fv_cnt;
            if (fv_cnt != 0) fv_digit = k * 8 + fv_at;
        end
        check("refill_fv_count", tot_fv, 32'd1);
        check("refill_fv_when", fv_digit, 32'd52);
        check("final_value", value, 32'hF654_3210);
        check("final_ok", {24'h0, digit_ok}, 32'hFF);
        check("final_blank", {24'h0, blank}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
